// File: rtl/uart_pkg.sv
// Shared constants, state types and baud divisor helper for the 8N1 UART.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 deserialiser on an already-synchronised line; mid-bit sampling, false-start and framing checks.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line,
  output logic [7:0] rxout,
  output logic       rxdone
);

  localparam int unsigned          CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]     CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_BITS - 1);

  rx_state_t              state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [BIT_IDX_W-1:0]   idx, idx_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic [7:0]             rxout_n;
  logic                   rxdone_n;
  logic                   wait_high, wait_high_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rxout     <= 8'h00;
      rxdone    <= 1'b0;
      wait_high <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      rxout     <= rxout_n;
      rxdone    <= rxdone_n;
      wait_high <= wait_high_n;
    end
  end

  // wait_high marks a framing error: hold in STOP until the line idles again
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shreg_n     = shreg;
    rxout_n     = rxout;
    rxdone_n    = 1'b0;
    wait_high_n = wait_high;
    case (state)
      RX_IDLE: begin
        cnt_n       = '0;
        idx_n       = '0;
        wait_high_n = 1'b0;
        if (line == START_BIT) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          state_n = (line == START_BIT) ? RX_DATA : RX_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          shreg_n = {line, shreg[DATA_BITS-1:1]};
          if (idx == IDX_LAST) state_n = RX_STOP;
          else                 idx_n   = idx + BIT_IDX_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (wait_high) begin
          if (line == STOP_BIT) begin
            wait_high_n = 1'b0;
            state_n     = RX_IDLE;
          end
        end else if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (line == STOP_BIT) begin
            rxout_n  = shreg;
            rxdone_n = 1'b1;
            state_n  = RX_IDLE;
          end else begin
            wait_high_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serialiser: latches a byte on start, emits start/data/stop bits, pulses txdone.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] txin,
  output logic       tx,
  output logic       txdone
);

  localparam int unsigned          CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]     CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_BITS - 1);

  tx_state_t              state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [BIT_IDX_W-1:0]   idx, idx_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic                   tx_n, txdone_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= TX_IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      tx     <= STOP_BIT;
      txdone <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      shreg  <= shreg_n;
      tx     <= tx_n;
      txdone <= txdone_n;
    end
  end

  // txdone is raised one clock early so the registered pulse lands in the stop bit's final clock
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shreg_n  = shreg;
    tx_n     = tx;
    txdone_n = 1'b0;
    case (state)
      TX_IDLE: begin
        tx_n  = STOP_BIT;
        cnt_n = '0;
        idx_n = '0;
        if (start) begin
          shreg_n = txin;
          tx_n    = START_BIT;
          state_n = TX_START;
        end
      end
      TX_START: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          tx_n    = shreg[0];
          shreg_n = shreg >> 1;
          state_n = TX_DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (idx == IDX_LAST) begin
            tx_n    = STOP_BIT;
            state_n = TX_STOP;
          end else begin
            idx_n   = idx + BIT_IDX_W'(1);
            tx_n    = shreg[0];
            shreg_n = shreg >> 1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        tx_n = STOP_BIT;
        if (cnt == CNT_DONE) txdone_n = 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = TX_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx_rx_top.sv
// 8N1 UART leaf: transmitter, receiver and the rx input synchroniser.
module uart_tx_rx_top
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 1_000_000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] txin,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] rxout,
  output logic       rxdone,
  output logic       txdone
);

  logic rx_meta, rx_sync;

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .txin   (txin),
    .tx     (tx),
    .txdone (txdone)
  );

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .line   (rx_sync),
    .rxout  (rxout),
    .rxdone (rxdone)
  );

endmodule

// File: tb/tb_uart_tx_rx_top.sv
// Self-checking bench for uart_tx_rx_top: vector table, scoreboard on rxdone, corner-case sequences.
module tb_uart_tx_rx_top;

  localparam int CPB  = 104;
  localparam int HALF = CPB / 2;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic [7:0] txin   = 8'h00;
  logic       loop   = 1'b1;
  logic       rx_drv = 1'b1;
  logic       tx, rx, rxdone, txdone;
  logic [7:0] rxout;

  assign rx = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_tx_rx_top #(.CLK_FREQ(1_000_000), .BAUD_RATE(9600)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .txin   (txin),
    .tx     (tx),
    .rx     (rx),
    .rxout  (rxout),
    .rxdone (rxdone),
    .txdone (txdone)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         rx_cnt = 0;
  int         tx_cnt = 0;
  int         rx_cyc = 0;
  logic [7:0] sb[$];
  logic [7:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every rxdone must match the oldest byte still expected
  always @(negedge clk) begin
    if (txdone) tx_cnt++;
    if (rxdone) begin
      rx_cnt++;
      rx_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rxdone: rxout=%h with no byte pending", rxout);
      end else begin
        mon_exp = sb.pop_front();
        if (rxout !== mon_exp) begin
          errors++;
          $display("FAIL rxout_scoreboard: got %h expected %h", rxout, mon_exp);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_txdone(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (txdone) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL txdone_timeout: no txdone within %0d cycles", budget);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic pulse_start(input logic [7:0] b);
    @(negedge clk);
    txin  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] txin;
    logic [9:0] frame;   // bit i = i-th bit on the wire
    logic [7:0] rx_exp;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] vals[10];
  bit         ok;
  int         rxc0, txc0, prev_cyc, lead;
  logic       any_low;

  initial begin
    vecs[0] = '{8'hA5, 10'b1101001010, 8'hA5};
    vecs[1] = '{8'h00, 10'b1000000000, 8'h00};
    vecs[2] = '{8'hFF, 10'b1111111110, 8'hFF};
    vecs[3] = '{8'h81, 10'b1100000010, 8'h81};
    vecs[4] = '{8'h3C, 10'b1001111000, 8'h3C};

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_rxout", 32'(rxout), 32'h00);
    check("reset_rxdone", 32'(rxdone), 32'd0);
    check("reset_txdone", 32'(txdone), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback vectors: bit-by-bit wire check, rxdone ahead of txdone
    for (int v = 0; v < 5; v++) begin
      rxc0 = rx_cnt;
      sb.push_back(vecs[v].rx_exp);
      pulse_start(vecs[v].txin);
      for (int i = 0; i < 10; i++) begin
        repeat ((i == 0) ? HALF - 1 : CPB) @(posedge clk);
        #1 check($sformatf("tx_bit_v%0d_b%0d", v, i), 32'(tx), 32'(vecs[v].frame[i]));
      end
      wait_txdone(2 * CPB, ok);
      if (ok) begin
        check($sformatf("rxdone_before_txdone_v%0d", v), 32'(rx_cnt), 32'(rxc0 + 1));
        lead = cyc - rx_cyc;
        check($sformatf("rx_lead_v%0d", v), 32'(lead >= HALF - 4 && lead <= HALF - 2), 32'd1);
      end
    end

    // Back-to-back with start held high
    for (int i = 0; i < 10; i++) vals[i] = 8'($urandom_range(200, 10));
    rxc0 = rx_cnt;
    @(negedge clk);
    txin  = vals[0];
    start = 1'b1;
    sb.push_back(vals[0]);
    prev_cyc = 0;
    for (int k = 0; k < 10; k++) begin
      wait_txdone(11 * CPB, ok);
      if (!ok) break;
      if (k > 0) check($sformatf("frame_spacing_%0d", k), 32'(cyc - prev_cyc), 32'(10 * CPB + 1));
      prev_cyc = cyc;
      if (k < 9) begin
        txin = vals[k + 1];
        sb.push_back(vals[k + 1]);
      end else begin
        start = 1'b0;
      end
    end
    repeat (2 * CPB) @(negedge clk);
    check("b2b_rx_count", 32'(rx_cnt), 32'(rxc0 + 10));
    check("b2b_sb_drained", 32'(sb.size()), 32'd0);

    // Reset during DATA discards the partial frame
    rxc0 = rx_cnt;
    pulse_start(8'h3C);
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_txdone", 32'(txdone), 32'd0);
    check("midrst_rxdone", 32'(rxdone), 32'd0);
    check("midrst_rxout", 32'(rxout), 32'h00);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sb.push_back(8'h81);
    pulse_start(8'h81);
    wait_txdone(11 * CPB, ok);
    @(negedge clk);
    check("midrst_rx_count", 32'(rx_cnt), 32'(rxc0 + 1));
    check("midrst_rxout_after", 32'(rxout), 32'h81);

    // False start: short low glitch must not produce a byte
    loop   = 1'b0;
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);
    rxc0   = rx_cnt;
    rx_drv = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("false_start_no_rxdone", 32'(rx_cnt), 32'(rxc0));
    sb.push_back(8'h5A);
    send_rx(8'h5A, 1'b1);
    repeat (CPB) @(negedge clk);
    check("false_start_recover_cnt", 32'(rx_cnt), 32'(rxc0 + 1));
    check("false_start_recover_val", 32'(rxout), 32'h5A);

    // Framing error: stop bit low
    rxc0 = rx_cnt;
    send_rx(8'hFF, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("framing_no_rxdone", 32'(rx_cnt), 32'(rxc0));
    check("framing_rxout_held", 32'(rxout), 32'h5A);
    sb.push_back(8'h33);
    send_rx(8'h33, 1'b1);
    repeat (CPB) @(negedge clk);
    check("framing_recover_cnt", 32'(rx_cnt), 32'(rxc0 + 1));

    // Idle line with start low
    loop    = 1'b1;
    start   = 1'b0;
    rxc0    = rx_cnt;
    txc0    = tx_cnt;
    any_low = 1'b0;
    repeat (5 * CPB) begin
      @(negedge clk);
      if (tx !== 1'b1) any_low = 1'b1;
    end
    check("idle_tx_high", 32'(any_low), 32'd0);
    check("idle_no_txdone", 32'(tx_cnt), 32'(txc0));
    check("idle_no_rxdone", 32'(rx_cnt), 32'(rxc0));
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
